// File: rtl/ballot_collector.sv
// -----------------------------------------------------------------------------
// ballot_collector
//
// Upstream feeder for the 5-bit majority stage. Collects one serial vote from
// each of voters 0..4 over a valid/ready interface and assembles them into a
// 5-bit ballot. The ballot is registered and held stable until the consumer
// accepts it. A round closes when all five voters have voted, or when
// TIMEOUT_CYCLES cycles have elapsed since the first accepted vote.
//
// Parameters
//   TIMEOUT_CYCLES  cycles from first accepted vote to forced close (>= 2)
//   TMR_W           round timer width
//
// Ports
//   clk           in   1  rising-edge clock
//   reset_n       in   1  synchronous active-low reset
//   vote_valid    in   1  vote_id / vote_bit valid
//   vote_ready    out  1  collector can accept a vote (low while holding)
//   vote_id       in   3  voter index; 0..4 legal, 5..7 illegal
//   vote_bit      in   1  vote value
//   ballot        out  5  ballot[i] = vote of voter i
//   ballot_valid  out  1  ballot complete and stable
//   ballot_ready  in   1  consumer accepts ballot
//   timed_out     out  1  current ballot closed by timeout (valid with ballot_valid)
//   dup_err       out  1  one-cycle pulse: duplicate vote dropped
//   id_err        out  1  one-cycle pulse: illegal vote_id dropped
//   ones_count    out  3  number of 1s in ballot (only with BALLOT_STATS_EN)
//
// Build option
//   BALLOT_STATS_EN  when defined, adds the registered ones_count output.
// -----------------------------------------------------------------------------
module ballot_collector #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vote_valid,
    output logic       vote_ready,
    input  logic [2:0] vote_id,
    input  logic       vote_bit,
    output logic [4:0] ballot,
    output logic       ballot_valid,
    input  logic       ballot_ready,
    output logic       timed_out,
    output logic       dup_err,
    output logic       id_err
`ifdef BALLOT_STATS_EN
    ,
    output logic [2:0] ones_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [4:0]       FULL_MASK  = 5'b11111;
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;

    logic [4:0]       mask;          // voters already recorded this round
    logic [4:0]       mask_nxt;
    logic [4:0]       ballot_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             timed_out_nxt;

    // Vote decode
    logic             vote_fire;
    logic             id_legal;
    logic [4:0]       vote_onehot;
    logic             is_dup;
    logic             record;
    logic [4:0]       mask_upd;
    logic [4:0]       ballot_upd;
    logic             mask_complete;
    logic             timer_done;

`ifdef BALLOT_STATS_EN
    function automatic logic [2:0] count_ones(input logic [4:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 5; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Vote decode. Illegal ids decode to an all-zero one-hot so they can never
    // touch the mask or ballot, and can never start a round.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        vote_fire   = vote_valid && vote_ready;
        id_legal    = (vote_id <= 3'd4);
        vote_onehot = 5'b00000;
        if (id_legal) begin
            vote_onehot = 5'b00001 << vote_id;
        end
        // First vote wins: a legal id already in the mask is a duplicate.
        is_dup     = |(mask & vote_onehot);
        record     = vote_fire && id_legal && !is_dup;
        mask_upd   = mask;
        ballot_upd = ballot;
        if (record) begin
            mask_upd   = mask | vote_onehot;
            // Unrecorded ballot bits are always 0, so OR-ing in the bit suffices.
            ballot_upd = ballot | (vote_bit ? vote_onehot : 5'b00000);
        end
        mask_complete = (mask_upd == FULL_MASK);
        timer_done    = (timer == TIMER_LAST);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                // Only a recorded (legal) vote opens a round.
                if (record) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                // A completing vote and a timeout on the same edge both close
                // the round; the vote has already been folded into mask_upd.
                if ((record && mask_complete) || timer_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ballot_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from registered state only, so there is no
    // combinational path from the vote inputs to the ballot side.
    // -------------------------------------------------------------------------
    always_comb begin
        vote_ready   = (state != HOLD);
        ballot_valid = (state == HOLD);
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        ballot_nxt    = ballot;
        mask_nxt      = mask;
        timer_nxt     = timer;
        timed_out_nxt = timed_out;
        unique case (state)
            IDLE: begin
                ballot_nxt    = ballot_upd;
                mask_nxt      = mask_upd;
                timer_nxt     = '0;
                timed_out_nxt = 1'b0;
            end
            COLLECT: begin
                ballot_nxt = ballot_upd;
                mask_nxt   = mask_upd;
                if (state_nxt == HOLD) begin
                    // Closing: a full mask means the round completed normally,
                    // even if the timer expired on the same edge.
                    timer_nxt     = '0;
                    timed_out_nxt = !mask_complete;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            HOLD: begin
                if (ballot_ready) begin
                    ballot_nxt    = '0;
                    mask_nxt      = '0;
                    timer_nxt     = '0;
                    timed_out_nxt = 1'b0;
                end
            end
            default: begin
                ballot_nxt    = '0;
                mask_nxt      = '0;
                timer_nxt     = '0;
                timed_out_nxt = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: ballot and mask are a handful of flops rather than a RAM, so they
    // are reset explicitly; a real memory array would be left unreset and
    // qualified by its valid mask instead.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ballot    <= '0;
            mask      <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
            dup_err   <= 1'b0;
            id_err    <= 1'b0;
`ifdef BALLOT_STATS_EN
            ones_count <= '0;
`endif
        end else begin
            ballot    <= ballot_nxt;
            mask      <= mask_nxt;
            timer     <= timer_nxt;
            timed_out <= timed_out_nxt;
            // Only one vote per cycle, so these two pulses are exclusive.
            dup_err   <= vote_fire && id_legal && is_dup;
            id_err    <= vote_fire && !id_legal;
`ifdef BALLOT_STATS_EN
            ones_count <= count_ones(ballot_nxt);
`endif
        end
    end

endmodule

// File: tb/tb_ballot_collector.sv
// -----------------------------------------------------------------------------
// tb_ballot_collector
//
// Self-checking bench for ballot_collector. Directed scenarios cover reset,
// back-to-back rounds, duplicates, timeout, illegal ids and reset mid-round;
// a randomized phase compares the DUT against a round-level model that tracks
// which voters have voted and how many edges have elapsed since the first vote.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ballot_collector;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       vote_valid;
    logic       vote_ready;
    logic [2:0] vote_id;
    logic       vote_bit;
    logic [4:0] ballot;
    logic       ballot_valid;
    logic       ballot_ready;
    logic       timed_out;
    logic       dup_err;
    logic       id_err;
`ifdef BALLOT_STATS_EN
    logic [2:0] ones_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ballot_collector #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vote_valid  (vote_valid),
        .vote_ready  (vote_ready),
        .vote_id     (vote_id),
        .vote_bit    (vote_bit),
        .ballot      (ballot),
        .ballot_valid(ballot_valid),
        .ballot_ready(ballot_ready),
        .timed_out   (timed_out),
        .dup_err     (dup_err),
        .id_err      (id_err)
`ifdef BALLOT_STATS_EN
        ,
        .ones_count  (ones_count)
`endif
    );

    // Stimulus helpers (no checking inside).
    task automatic drive_vote(input logic [2:0] id, input logic b);
        vote_valid = 1'b1;
        vote_id    = id;
        vote_bit   = b;
        @(negedge clk);
        vote_valid = 1'b0;
    endtask

    task automatic release_ballot();
        ballot_ready = 1'b1;
        @(negedge clk);
        ballot_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset_n      = 1'b0;
        vote_valid   = 1'b0;
        vote_id      = 3'd0;
        vote_bit     = 1'b0;
        ballot_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (ballot !== 5'b00000) begin failures++; $display("FAIL reset_ballot got=%b exp=00000", ballot); end
        checks++; if (ballot_valid !== 1'b0) begin failures++; $display("FAIL reset_ballot_valid got=%b exp=0", ballot_valid); end
        checks++; if (vote_ready !== 1'b1) begin failures++; $display("FAIL reset_vote_ready got=%b exp=1", vote_ready); end
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL reset_timed_out got=%b exp=0", timed_out); end
        checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL reset_dup_err got=%b exp=0", dup_err); end
        checks++; if (id_err !== 1'b0) begin failures++; $display("FAIL reset_id_err got=%b exp=0", id_err); end
`ifdef BALLOT_STATS_EN
        checks++; if (ones_count !== 3'd0) begin failures++; $display("FAIL reset_ones_count got=%0d exp=0", ones_count); end
`endif
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [2:0] ids [5];
        logic       bits[5];
        ids  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        bits = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive_vote(ids[i], bits[i]);
            if (i < 4) begin
                checks++; if (ballot_valid !== 1'b0) begin failures++; $display("FAIL b2b_early_valid vote=%0d got=%b exp=0", i, ballot_valid); end
            end
        end
        checks++; if (ballot_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", ballot_valid); end
        checks++; if (ballot !== 5'b10011) begin failures++; $display("FAIL b2b_ballot got=%b exp=10011", ballot); end
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL b2b_timed_out got=%b exp=0", timed_out); end
        checks++; if (vote_ready !== 1'b0) begin failures++; $display("FAIL b2b_vote_ready got=%b exp=0", vote_ready); end
`ifdef BALLOT_STATS_EN
        checks++; if (ones_count !== 3'd3) begin failures++; $display("FAIL b2b_ones_count got=%0d exp=3", ones_count); end
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (ballot !== 5'b10011 || ballot_valid !== 1'b1) begin
                failures++; $display("FAIL b2b_hold cycle=%0d got=%b/%b exp=10011/1", k, ballot, ballot_valid);
            end
        end
        release_ballot();
        checks++; if (ballot_valid !== 1'b0) begin failures++; $display("FAIL b2b_release_valid got=%b exp=0", ballot_valid); end
        checks++; if (vote_ready !== 1'b1) begin failures++; $display("FAIL b2b_release_ready got=%b exp=1", vote_ready); end
        checks++; if (ballot !== 5'b00000) begin failures++; $display("FAIL b2b_release_ballot got=%b exp=00000", ballot); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_duplicate();
        int         dup_pulses;
        logic [2:0] rest[4];
        rest       = '{3'd0, 3'd1, 3'd3, 3'd4};
        dup_pulses = 0;
        drive_vote(3'd2, 1'b1);
        if (dup_err === 1'b1) dup_pulses++;
        drive_vote(3'd2, 1'b0);
        checks++; if (dup_err !== 1'b1) begin failures++; $display("FAIL dup_pulse got=%b exp=1", dup_err); end
        if (dup_err === 1'b1) dup_pulses++;
        for (int i = 0; i < 4; i++) begin
            drive_vote(rest[i], 1'b1);
            if (dup_err === 1'b1) dup_pulses++;
        end
        checks++; if (dup_pulses !== 1) begin failures++; $display("FAIL dup_pulse_count got=%0d exp=1", dup_pulses); end
        checks++; if (ballot !== 5'b11111) begin failures++; $display("FAIL dup_ballot got=%b exp=11111", ballot); end
        checks++; if (ballot_valid !== 1'b1 || timed_out !== 1'b0) begin
            failures++; $display("FAIL dup_close got=%b/%b exp=1/0", ballot_valid, timed_out);
        end
        release_ballot();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_timeout();
        drive_vote(3'd1, 1'b1);  // accepted at edge t0
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == 5) drive_vote(3'd3, 1'b1);
            else @(negedge clk);
            checks++; if (ballot_valid !== (k == TIMEOUT)) begin
                failures++; $display("FAIL timeout_valid edge=t0+%0d got=%b exp=%b", k, ballot_valid, (k == TIMEOUT));
            end
        end
        checks++; if (ballot !== 5'b01010) begin failures++; $display("FAIL timeout_ballot got=%b exp=01010", ballot); end
        checks++; if (timed_out !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", timed_out); end
        // A vote offered while holding must be ignored.
        drive_vote(3'd0, 1'b1);
        checks++; if (ballot !== 5'b01010 || dup_err !== 1'b0 || id_err !== 1'b0) begin
            failures++; $display("FAIL timeout_hold_vote got=%b dup=%b id=%b exp=01010 0 0", ballot, dup_err, id_err);
        end
        release_ballot();
        checks++; if (timed_out !== 1'b0 || ballot_valid !== 1'b0) begin
            failures++; $display("FAIL timeout_release got=%b/%b exp=0/0", timed_out, ballot_valid);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_illegal_id();
        drive_vote(3'd5, 1'b1);
        checks++; if (id_err !== 1'b1) begin failures++; $display("FAIL id_err_pulse got=%b exp=1", id_err); end
        checks++; if (dup_err !== 1'b0) begin failures++; $display("FAIL id_err_dup got=%b exp=0", dup_err); end
        checks++; if (ballot !== 5'b00000 || vote_ready !== 1'b1) begin
            failures++; $display("FAIL id_err_state got=%b/%b exp=00000/1", ballot, vote_ready);
        end
        @(negedge clk);
        checks++; if (id_err !== 1'b0) begin failures++; $display("FAIL id_err_width got=%b exp=0", id_err); end
        // Had the illegal vote opened a round, it would time out in this window.
        repeat (TIMEOUT + 4) @(negedge clk);
        checks++; if (ballot_valid !== 1'b0) begin failures++; $display("FAIL id_err_no_round got=%b exp=0", ballot_valid); end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_round();
        drive_vote(3'd0, 1'b1);
        drive_vote(3'd1, 1'b1);
        drive_vote(3'd2, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (ballot !== 5'b00000 || ballot_valid !== 1'b0 || vote_ready !== 1'b1) begin
            failures++; $display("FAIL midreset_clear got=%b/%b/%b exp=00000/0/1", ballot, ballot_valid, vote_ready);
        end
        drive_vote(3'd0, 1'b0);
        drive_vote(3'd1, 1'b1);
        drive_vote(3'd2, 1'b0);
        drive_vote(3'd3, 1'b0);
        drive_vote(3'd4, 1'b0);
        checks++; if (ballot !== 5'b00010 || ballot_valid !== 1'b1 || timed_out !== 1'b0) begin
            failures++; $display("FAIL midreset_round got=%b/%b/%b exp=00010/1/0", ballot, ballot_valid, timed_out);
        end
        release_ballot();
    endtask

    // -------------------------------------------------------------------------
    // Randomized rounds against a round-level model: a voter set, their first
    // votes, and the edge count since the round's first recorded vote.
    // -------------------------------------------------------------------------
    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            logic [4:0] seen;
            logic [4:0] val;
            int         cnt;
            int         e;
            bit         started;
            bit         closed;
            bit         exp_to;
            bit         exp_id;
            bit         exp_dup;
            bit         v;
            logic [2:0] id;
            logic       b;
            int         hold_cycles;
            seen    = '0;
            val     = '0;
            cnt     = 0;
            e       = 0;
            started = 0;
            closed  = 0;
            exp_to  = 0;
            for (int c = 0; c < 80 && !closed; c++) begin
                if (!started && c >= 20) begin
                    v  = 1'b1;
                    id = 3'($urandom_range(0, 4));
                end else begin
                    v  = ($urandom_range(0, 3) != 0);
                    id = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                end
                b            = 1'($urandom_range(0, 1));
                vote_valid   = v;
                vote_id      = id;
                vote_bit     = b;
                ballot_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                exp_id  = 0;
                exp_dup = 0;
                if (started) e++;
                if (v) begin
                    if (id > 3'd4) exp_id = 1;
                    else if (seen[id]) exp_dup = 1;
                    else begin
                        seen[id] = 1'b1;
                        val[id]  = b;
                        cnt++;
                        if (!started) begin
                            started = 1;
                            e       = 0;
                        end
                    end
                end
                if (started && cnt == 5) begin
                    closed = 1;
                    exp_to = 0;
                end else if (started && e == TIMEOUT) begin
                    closed = 1;
                    exp_to = 1;
                end
                checks++; if (id_err !== exp_id || dup_err !== exp_dup || ballot_valid !== closed) begin
                    failures++;
                    $display("FAIL rnd_cycle round=%0d cyc=%0d got id=%b dup=%b bv=%b exp id=%b dup=%b bv=%b",
                             r, c, id_err, dup_err, ballot_valid, exp_id, exp_dup, closed);
                end
            end
            vote_valid   = 1'b0;
            ballot_ready = 1'b0;
            if (!closed) begin
                checks++; failures++;
                $display("FAIL rnd_no_close round=%0d got=open exp=closed", r);
            end
            checks++; if (ballot !== val || timed_out !== exp_to) begin
                failures++; $display("FAIL rnd_ballot round=%0d got=%b/%b exp=%b/%b", r, ballot, timed_out, val, exp_to);
            end
`ifdef BALLOT_STATS_EN
            checks++; if (ones_count !== 3'($countones(val))) begin
                failures++; $display("FAIL rnd_ones_count round=%0d got=%0d exp=%0d", r, ones_count, $countones(val));
            end
`endif
            hold_cycles = $urandom_range(0, 3);
            for (int h = 0; h < hold_cycles; h++) begin
                vote_valid = 1'($urandom_range(0, 1));
                vote_id    = 3'($urandom_range(0, 7));
                vote_bit   = 1'($urandom_range(0, 1));
                @(negedge clk);
                checks++; if (ballot !== val || ballot_valid !== 1'b1 || vote_ready !== 1'b0 || dup_err !== 1'b0 || id_err !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_hold round=%0d got=%b bv=%b vr=%b dup=%b id=%b exp=%b 1 0 0 0",
                             r, ballot, ballot_valid, vote_ready, dup_err, id_err, val);
                end
            end
            vote_valid = 1'b0;
            release_ballot();
            checks++; if (ballot_valid !== 1'b0 || ballot !== 5'b00000 || timed_out !== 1'b0) begin
                failures++; $display("FAIL rnd_release round=%0d got=%b/%b/%b exp=0/00000/0", r, ballot_valid, ballot, timed_out);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_duplicate();
        test_timeout();
        test_illegal_id();
        test_reset_mid_round();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
